// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer: FSM states, command byte
// field positions and the address range check.
package spi_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    FETCH,
    LOAD,
    RD_DATA,
    DRAIN
  } state_t;

  localparam int CMD_W_BIT    = 7;
  localparam int CMD_INC_BIT  = 6;
  localparam int CMD_ADDR_MSB = 5;

  // A command address is only legal when every bit above the bank width is zero.
  function automatic logic addr_fits(input logic [CMD_ADDR_MSB:0] cmd_addr,
                                     input int addr_w);
    return (cmd_addr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/spi_cmd_timeout.sv
// Watchdog counter for the SPI command sequencer: flags when no byte has
// arrived for CYCLES enabled clock cycles.
module spi_cmd_timeout #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between an SPI slave byte interface and an 8-bit register bank.
// Optional byte watchdog enabled with the SPI_CMD_TIMEOUT_EN macro.
module spi_cmd_ctrl
  import spi_cmd_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic [7:0]        tx_data,
  output logic              tx_latch,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              err
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inc_q, inc_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              tx_latch_q, tx_latch_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              err_q, err_d;
  logic              timeout_hit;

`ifdef SPI_CMD_TIMEOUT_EN
  logic to_enable;

  assign to_enable = !ss && ((state_q == WR_DATA) || (state_q == RD_DATA));

  spi_cmd_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_rdy || !to_enable),
    .enable (to_enable),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inc_q      <= 1'b0;
      tx_data_q  <= '0;
      wdata_q    <= '0;
      tx_latch_q <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inc_q      <= inc_d;
      tx_data_q  <= tx_data_d;
      wdata_q    <= wdata_d;
      tx_latch_q <= tx_latch_d;
      we_q       <= we_d;
      re_q       <= re_d;
      err_q      <= err_d;
    end
  end

  // Strobes are registered one cycle after the deciding rx_rdy; ss high always wins.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    inc_d      = inc_q;
    tx_data_d  = tx_data_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    tx_latch_d = 1'b0;
    we_d       = 1'b0;
    re_d       = 1'b0;

    if (we_q && inc_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (ss) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_rdy) begin
            if (addr_fits(rx_data[CMD_ADDR_MSB:0], ADDR_W)) begin
              err_d  = 1'b0;
              inc_d  = rx_data[CMD_INC_BIT];
              addr_d = rx_data[ADDR_W-1:0];
              if (rx_data[CMD_W_BIT]) begin
                state_d = WR_DATA;
              end else begin
                state_d = FETCH;
                re_d    = 1'b1;
              end
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
        end
        WR_DATA: begin
          if (rx_rdy) begin
            we_d    = 1'b1;
            wdata_d = rx_data;
          end else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
        FETCH: begin
          if (rx_rdy) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end
        // Read data from the bank is valid now, one cycle after the read strobe.
        LOAD: begin
          if (rx_rdy) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            tx_data_d  = reg_rdata;
            tx_latch_d = 1'b1;
            state_d    = RD_DATA;
          end
        end
        RD_DATA: begin
          if (rx_rdy) begin
            if (inc_q) begin
              addr_d = addr_q + ADDR_W'(1);
            end
            re_d    = 1'b1;
            state_d = FETCH;
          end else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          state_d = DRAIN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_latch  = tx_latch_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus queues expected strobes, a
// negedge monitor pops and compares them as the DUT presents them.
module tb_spi_cmd_ctrl;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ss;
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic [7:0]        tx_data;
  logic              tx_latch;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata = 8'h00;
  logic              busy;
  logic              err;

  spi_cmd_ctrl #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .tx_data  (tx_data),
    .tx_latch (tx_latch),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank fixture the controller talks to
  logic [7:0] bank [0:31];
  always @(posedge clk) begin
    if (reg_we) bank[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= bank[reg_addr];
  end

  typedef struct {
    int cyc;
    int addr;
    int data;
  } exp_t;

  exp_t wr_q[$];
  exp_t re_q[$];
  exp_t tx_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic unexpected(input string name, input int value);
    checks++;
    errors++;
    $display("[TB] FAIL %s: strobe with value 0x%0h, none expected (cycle %0d)", name, value, cyc);
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (reg_we) begin
        if (wr_q.size() == 0) unexpected("unexpected_write", int'(reg_addr));
        else begin
          e = wr_q.pop_front();
          check_output("write_addr", int'(reg_addr), e.addr);
          check_output("write_data", int'(reg_wdata), e.data);
          check_output("write_cycle", cyc, e.cyc);
        end
      end
      if (reg_re) begin
        if (re_q.size() == 0) unexpected("unexpected_read", int'(reg_addr));
        else begin
          e = re_q.pop_front();
          check_output("read_addr", int'(reg_addr), e.addr);
          check_output("read_cycle", cyc, e.cyc);
        end
      end
      if (tx_latch) begin
        if (tx_q.size() == 0) unexpected("unexpected_tx_latch", int'(tx_data));
        else begin
          e = tx_q.pop_front();
          check_output("tx_data", int'(tx_data), e.data);
          check_output("tx_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] b, output int n);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_rdy  = 1'b1;
    n       = cyc;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
  endtask

  task automatic set_ss(input logic v);
    @(posedge clk);
    #1;
    ss = v;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push_write(input int c, input int a, input int d);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic push_read(input int c, input int a, input int d);
    exp_t e;
    e.cyc = c + 1; e.addr = a; e.data = 0;
    re_q.push_back(e);
    e.cyc = c + 3; e.data = d;
    tx_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) bank[i] = 8'(i + 8'h80);
    bank[31] = 8'hAA;
    bank[0]  = 8'h55;
    bank[1]  = 8'h5A;
    rst = 1'b1; ss = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
    #22;
    check_output("reset_busy", busy, 0);
    check_output("reset_err", err, 0);
    check_output("reset_strobes", {reg_we, reg_re, tx_latch}, 0);
    check_output("reset_tx_data", tx_data, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // Write burst with increment
    set_ss(1'b0);
    apply_stimulus(8'hC3, n);
    check_output("wr_busy", busy, 1);
    apply_stimulus(8'h11, n); push_write(n + 1, 3, 8'h11);
    apply_stimulus(8'h22, n); push_write(n + 1, 4, 8'h22);
    apply_stimulus(8'h33, n); push_write(n + 1, 5, 8'h33);
    idle(2);
    set_ss(1'b1);
    idle(2);
    check_output("idle_busy", busy, 0);

    // Read with address wrap 31 -> 0 -> 1
    set_ss(1'b0);
    apply_stimulus(8'h5F, n); push_read(n, 31, 8'hAA);
    idle(4);
    apply_stimulus(8'h00, n); push_read(n, 0, 8'h55);
    idle(4);
    apply_stimulus(8'h00, n); push_read(n, 1, 8'h5A);
    idle(4);
    set_ss(1'b1);
    idle(2);

    // Write without increment
    set_ss(1'b0);
    apply_stimulus(8'h87, n);
    apply_stimulus(8'h01, n); push_write(n + 1, 7, 8'h01);
    apply_stimulus(8'h02, n); push_write(n + 1, 7, 8'h02);
    idle(2);
    set_ss(1'b1);
    idle(1);
    check_output("bank7", int'(bank[7]), 8'h02);

    // Out-of-range address, sticky error, cleared by next valid command
    set_ss(1'b0);
    apply_stimulus(8'hA0, n);
    check_output("badaddr_err", err, 1);
    check_output("badaddr_busy", busy, 1);
    apply_stimulus(8'h44, n);
    idle(2);
    set_ss(1'b1);
    idle(2);
    check_output("err_sticky", err, 1);
    check_output("drain_exit_busy", busy, 0);
    set_ss(1'b0);
    apply_stimulus(8'h00, n); push_read(n, 0, 8'h55);
    check_output("err_cleared", err, 0);
    idle(4);
    set_ss(1'b1);
    idle(2);

    // Abort: ss rises in the same cycle as a data byte
    set_ss(1'b0);
    apply_stimulus(8'hC8, n);
    apply_stimulus(8'h77, n); push_write(n + 1, 8, 8'h77);
    @(posedge clk); #1;
    ss = 1'b1; rx_data = 8'h99; rx_rdy = 1'b1;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    check_output("abort_busy", busy, 0);
    idle(3);

    // Reset in the middle of a read
    set_ss(1'b0);
    apply_stimulus(8'h41, n);
    begin
      exp_t e;
      e.cyc = n + 1; e.addr = 1; e.data = 0;
      re_q.push_back(e);
    end
    @(negedge clk);
    #1; rst = 1'b1;
    #1;
    check_output("midreset_outputs",
                 {tx_data, tx_latch, reg_wdata, reg_we, reg_re, busy, err}, 0);
    check_output("midreset_addr", int'(reg_addr), 0);
    ss = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    idle(4);

    // Overrun: second byte arrives while the first read is still in flight
    set_ss(1'b0);
    apply_stimulus(8'h02, n);
    begin
      exp_t e;
      e.cyc = n + 1; e.addr = 2; e.data = 0;
      re_q.push_back(e);
    end
    apply_stimulus(8'h00, n);
    check_output("overrun_err", err, 1);
    idle(4);
    set_ss(1'b1);
    idle(2);

    // Byte watchdog
    set_ss(1'b0);
    apply_stimulus(8'hC0, n);
    check_output("timeout_cmd_err", err, 0);
    idle(20);
`ifdef SPI_CMD_TIMEOUT_EN
    check_output("timeout_err", err, 1);
`else
    check_output("no_timeout_err", err, 0);
`endif
    check_output("timeout_busy", busy, 1);
    set_ss(1'b1);
    idle(2);
    check_output("final_busy", busy, 0);

    check_output("pending_writes", wr_q.size(), 0);
    check_output("pending_reads", re_q.size(), 0);
    check_output("pending_tx", tx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
